// File: rtl/bus_cycle_if.sv
// bus_cycle_if: request, responder and bus-data signals of bus_cycle.
// master = requester/responder side, slave = the bus_cycle sequencer.
interface bus_cycle_if;
    logic        REQ_I;
    logic [1:0]  CYC_I;
    logic [13:0] ADDR_I;
    logic [7:0]  WDAT_I;
    logic        READY_I;
    logic [7:0]  DAT_I;
    logic        SYNC_O;
    logic [2:0]  STATE_O;
    logic [7:0]  DAT_O;
    logic        DAT_OE_O;
    logic [7:0]  RDAT_O;
    logic        ACK_O;
    logic        ERR_O;
    logic        BUSY_O;

    modport master (
        output REQ_I, CYC_I, ADDR_I, WDAT_I, READY_I, DAT_I,
        input  SYNC_O, STATE_O, DAT_O, DAT_OE_O,
        input  RDAT_O, ACK_O, ERR_O, BUSY_O
    );

    modport slave (
        input  REQ_I, CYC_I, ADDR_I, WDAT_I, READY_I, DAT_I,
        output SYNC_O, STATE_O, DAT_O, DAT_OE_O,
        output RDAT_O, ACK_O, ERR_O, BUSY_O
    );
endinterface

// File: rtl/bus_cycle.sv
// bus_cycle: two-clock-per-state T1/T2/WAIT/T3 bus cycle sequencer.
// Ports: CLK_I, RST_I (sync, active high), bus (bus_cycle_if.slave).
module bus_cycle #(
    parameter logic [7:0] WAIT_MAX = 8'd255
) (
    input  logic         CLK_I,
    input  logic         RST_I,
    bus_cycle_if.slave   bus
);

    typedef enum logic [2:0] {
        S_WAIT = 3'b000,
        S_T3   = 3'b001,
        S_T1   = 3'b010,
        S_IDLE = 3'b011,
        S_T2   = 3'b100
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_phase;
    logic        w_phase_nxt;

    logic [1:0]  r_cyc;
    logic [13:0] r_addr;
    logic [7:0]  r_wdat;
    logic [7:0]  r_rdat;
    logic [7:0]  r_wcnt;
    logic        r_ack;
    logic        r_err;

    logic        w_accept;
    logic        w_capture;
    logic        w_ack_nxt;
    logic        w_err_nxt;
    logic        w_wcnt_inc;
    logic        w_is_wr;
    logic [7:0]  w_dat;
    logic        w_oe;

    assign w_is_wr = (r_cyc == 2'b11);

    // r_phase = 0 is the first clock of a state, 1 the second.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_wcnt_inc  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_phase_nxt = 1'b0;
                if (bus.REQ_I) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_T1;
                end
            end
            S_T1: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    w_state_nxt = S_T2;
                end
            end
            S_T2: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (bus.READY_I) begin
                        w_state_nxt = S_T3;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_inc  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (bus.READY_I) begin
                        w_state_nxt = S_T3;
                    end else if (r_wcnt >= WAIT_MAX) begin
                        // Ready still low after the last tolerated WAIT.
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_inc  = 1'b1;
                    end
                end
            end
            S_T3: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    w_capture   = !w_is_wr;
                    w_ack_nxt   = 1'b1;
                    if (bus.REQ_I) begin
                        // Back-to-back: skip IDLE.
                        w_accept    = 1'b1;
                        w_state_nxt = S_T1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_cyc  <= 2'b00;
            r_addr <= 14'h0000;
            r_wdat <= 8'h00;
            r_rdat <= 8'h00;
            r_wcnt <= 8'h00;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_ack <= w_ack_nxt;
            r_err <= w_err_nxt;
            if (w_accept) begin
                r_cyc  <= bus.CYC_I;
                r_addr <= bus.ADDR_I;
                r_wdat <= bus.WDAT_I;
                r_wcnt <= 8'h00;
            end else if (w_wcnt_inc) begin
                r_wcnt <= r_wcnt + 8'd1;
            end
            if (w_capture) begin
                r_rdat <= bus.DAT_I;
            end
        end
    end

    // Bus data is forced to zero whenever it is not driven.
    always_comb begin
        w_dat = 8'h00;
        w_oe  = 1'b0;
        unique case (r_state)
            S_T1: begin
                w_dat = r_addr[7:0];
                w_oe  = 1'b1;
            end
            S_T2: begin
                w_dat = {r_cyc, r_addr[13:8]};
                w_oe  = 1'b1;
            end
            S_T3: begin
                if (w_is_wr) begin
                    w_dat = r_wdat;
                    w_oe  = 1'b1;
                end
            end
            default: begin
                w_dat = 8'h00;
                w_oe  = 1'b0;
            end
        endcase
    end

    assign bus.SYNC_O   = (r_state != S_IDLE) && !r_phase;
    assign bus.STATE_O  = r_state;
    assign bus.DAT_O    = w_dat;
    assign bus.DAT_OE_O = w_oe;
    assign bus.RDAT_O   = r_rdat;
    assign bus.ACK_O    = r_ack;
    assign bus.ERR_O    = r_err;
    assign bus.BUSY_O   = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_cycle.sv
// tb_bus_cycle: directed vectors, expectation queue, negedge monitor.
// Responder drives READY_I/DAT_I per queued cycle settings.
module tb_bus_cycle;

    localparam logic [7:0] WMAX = 8'd4;
    localparam logic [2:0] ST_WAIT = 3'b000;
    localparam logic [2:0] ST_T3   = 3'b001;
    localparam logic [2:0] ST_T1   = 3'b010;
    localparam logic [2:0] ST_IDLE = 3'b011;
    localparam logic [2:0] ST_T2   = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_cycle_if bus ();

    bus_cycle #(.WAIT_MAX(WMAX)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  cyc;
        logic [13:0] addr;
        logic [7:0]  wdat;
        int          nwait;
        logic [7:0]  dat;
        logic [7:0]  t1;
        logic [7:0]  t2;
        logic [7:0]  t3;
        logic        oe3;
        logic [7:0]  rdat;
        logic        err;
        int          waits;
        int          lat;
    } vec_t;

    typedef struct {
        int         nwait;
        logic [7:0] dat;
    } resp_t;

    vec_t  vt [8];
    vec_t  expq [$];
    resp_t respq [$];

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic vec_t mk(logic [1:0] cyc, logic [13:0] addr,
                                logic [7:0] wdat, int nwait,
                                logic [7:0] dat, logic [7:0] t1,
                                logic [7:0] t2, logic [7:0] t3,
                                logic oe3, logic [7:0] rdat,
                                logic err, int waits, int lat);
        vec_t v;
        v.cyc = cyc; v.addr = addr; v.wdat = wdat;
        v.nwait = nwait; v.dat = dat;
        v.t1 = t1; v.t2 = t2; v.t3 = t3; v.oe3 = oe3;
        v.rdat = rdat; v.err = err; v.waits = waits; v.lat = lat;
        return v;
    endfunction

    // Responder: READY_I goes high once nwait WAIT states have passed.
    resp_t r_cur;
    int    r_wc;
    initial begin
        r_cur.nwait = 0;
        r_cur.dat   = 8'h00;
        r_wc        = 0;
        bus.READY_I = 1'b0;
        bus.DAT_I   = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.STATE_O == ST_T1 && bus.SYNC_O) begin
                r_wc = 0;
                if (respq.size() > 0) r_cur = respq.pop_front();
            end else if (bus.STATE_O == ST_WAIT && bus.SYNC_O) begin
                r_wc++;
            end
            bus.READY_I = (r_wc >= r_cur.nwait);
            bus.DAT_I   = (bus.STATE_O == ST_T3) ? r_cur.dat : 8'hEE;
        end
    end

    // Monitor: per-clock invariants, and compare on ACK_O/ERR_O.
    int         m_lat;
    bit         m_cnt;
    logic [7:0] m_t1, m_t2, m_t3;
    logic       m_oe3;
    int         m_w;
    logic [2:0] m_pst;
    logic       m_psync;
    vec_t       m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_cnt   = 1'b0;
            m_pst   = ST_IDLE;
            m_psync = 1'b0;
        end else begin
            if (!bus.DAT_OE_O) check("dat_zero", bus.DAT_O, 0);
            check("busy", bus.BUSY_O, bus.STATE_O != ST_IDLE);
            if (bus.STATE_O == ST_IDLE)
                check("idle_sync", bus.SYNC_O, 0);
            else if (!bus.SYNC_O)
                check("state_2nd", {m_pst, m_psync},
                      {bus.STATE_O, 1'b1});
            else
                check("sync_prev", m_psync, 0);
            if (m_cnt) m_lat++;
            if (bus.ACK_O || bus.ERR_O) begin
                if (expq.size() == 0) begin
                    check("unexpected_resp", {bus.ACK_O, bus.ERR_O}, 0);
                end else begin
                    m_e = expq.pop_front();
                    check("ack", bus.ACK_O, !m_e.err);
                    check("err", bus.ERR_O, m_e.err);
                    check("t1_dat", m_t1, m_e.t1);
                    check("t2_dat", m_t2, m_e.t2);
                    if (!m_e.err) begin
                        check("t3_dat", m_t3, m_e.t3);
                        check("t3_oe", m_oe3, m_e.oe3);
                    end
                    check("rdat", bus.RDAT_O, m_e.rdat);
                    check("waits", m_w, m_e.waits);
                    check("latency", m_lat, m_e.lat);
                end
                m_cnt = 1'b0;
            end
            if (bus.STATE_O == ST_T1 && bus.SYNC_O) begin
                m_cnt = 1'b1;
                m_lat = 1;
                m_w   = 0;
                m_t1  = bus.DAT_O;
                check("t1_oe", bus.DAT_OE_O, 1);
            end
            if (bus.STATE_O == ST_T2 && bus.SYNC_O) begin
                m_t2 = bus.DAT_O;
                check("t2_oe", bus.DAT_OE_O, 1);
            end
            if (bus.STATE_O == ST_WAIT) begin
                if (bus.SYNC_O) m_w++;
                check("wait_oe", bus.DAT_OE_O, 0);
            end
            if (bus.STATE_O == ST_T3 && bus.SYNC_O) begin
                m_t3  = bus.DAT_O;
                m_oe3 = bus.DAT_OE_O;
            end
            m_pst   = bus.STATE_O;
            m_psync = bus.SYNC_O;
        end
    end

    task automatic drive(input vec_t v);
        bus.CYC_I  = v.cyc;
        bus.ADDR_I = v.addr;
        bus.WDAT_I = v.wdat;
    endtask

    task automatic wait_t1();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.STATE_O == ST_T1 && bus.SYNC_O) begin
                ok = 1'b1;
                break;
            end
        end
        check("t1_timeout", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!bus.BUSY_O) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", ok, 1);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_state"}, bus.STATE_O, ST_IDLE);
        check({tag, "_sync"}, bus.SYNC_O, 0);
        check({tag, "_dat"}, bus.DAT_O, 0);
        check({tag, "_oe"}, bus.DAT_OE_O, 0);
        check({tag, "_rdat"}, bus.RDAT_O, 0);
        check({tag, "_ack"}, bus.ACK_O, 0);
        check({tag, "_err"}, bus.ERR_O, 0);
        check({tag, "_busy"}, bus.BUSY_O, 0);
    endtask

    // Single cycle; inputs are scrambled after acceptance.
    task automatic run(input int idx);
        resp_t r;
        r.nwait = vt[idx].nwait;
        r.dat   = vt[idx].dat;
        respq.push_back(r);
        expq.push_back(vt[idx]);
        drive(vt[idx]);
        bus.REQ_I = 1'b1;
        wait_t1();
        bus.REQ_I  = 1'b0;
        bus.CYC_I  = ~vt[idx].cyc;
        bus.ADDR_I = ~vt[idx].addr;
        bus.WDAT_I = ~vt[idx].wdat;
        wait_idle();
    endtask

    initial begin
        resp_t      r;
        logic [2:0] lp;
        bit         ok;

        vt[0] = mk(2'b10, 14'h1234, 8'h00, 0, 8'hA5,
                   8'h34, 8'h92, 8'h00, 1'b0, 8'hA5, 1'b0, 0, 7);
        vt[1] = mk(2'b11, 14'h1010, 8'h5A, 0, 8'h33,
                   8'h10, 8'hD0, 8'h5A, 1'b1, 8'hA5, 1'b0, 0, 7);
        vt[2] = mk(2'b00, 14'h0ABC, 8'h00, 3, 8'hC3,
                   8'hBC, 8'h0A, 8'h00, 1'b0, 8'hC3, 1'b0, 3, 13);
        vt[3] = mk(2'b01, 14'h3FFF, 8'h00, 4, 8'h7E,
                   8'hFF, 8'h7F, 8'h00, 1'b0, 8'h7E, 1'b0, 4, 15);
        vt[4] = mk(2'b10, 14'h2001, 8'h00, 1000, 8'h11,
                   8'h01, 8'hA0, 8'h00, 1'b0, 8'h7E, 1'b1, 4, 13);
        vt[5] = mk(2'b11, 14'h0000, 8'hFF, 0, 8'h22,
                   8'h00, 8'hC0, 8'hFF, 1'b1, 8'h7E, 1'b0, 0, 7);
        vt[6] = mk(2'b10, 14'h0155, 8'h00, 0, 8'h66,
                   8'h55, 8'h81, 8'h00, 1'b0, 8'h66, 1'b0, 0, 7);
        vt[7] = mk(2'b11, 14'h2AAA, 8'h3C, 1, 8'h44,
                   8'hAA, 8'hEA, 8'h3C, 1'b1, 8'h66, 1'b0, 1, 9);

        bus.REQ_I  = 1'b1;
        bus.CYC_I  = 2'b00;
        bus.ADDR_I = 14'h0000;
        bus.WDAT_I = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        bus.REQ_I = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", bus.STATE_O, ST_IDLE);

        for (int i = 0; i < 6; i++) run(i);

        // Reset in the first clock of T2; no response expected.
        r.nwait = 0;
        r.dat   = 8'h99;
        respq.push_back(r);
        drive(vt[0]);
        bus.REQ_I = 1'b1;
        wait_t1();
        bus.REQ_I = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_t2", bus.STATE_O, ST_T2);
        bus.REQ_I = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_t2");
        @(negedge clk);
        check("rst_req_ignored", bus.STATE_O, ST_IDLE);
        bus.REQ_I = 1'b0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_stays_idle", bus.BUSY_O, 0);

        // Back-to-back: REQ_I held high across two cycles.
        r.nwait = vt[6].nwait; r.dat = vt[6].dat;
        respq.push_back(r);
        r.nwait = vt[7].nwait; r.dat = vt[7].dat;
        respq.push_back(r);
        expq.push_back(vt[6]);
        expq.push_back(vt[7]);
        drive(vt[6]);
        bus.REQ_I = 1'b1;
        wait_t1();
        drive(vt[7]);
        ok = 1'b0;
        lp = ST_T1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("b2b_busy", bus.BUSY_O, 1);
            if (bus.STATE_O == ST_T1 && bus.SYNC_O) begin
                ok = 1'b1;
                break;
            end
            lp = bus.STATE_O;
        end
        check("b2b_t1_seen", ok, 1);
        check("b2b_prev_t3", lp, ST_T3);
        bus.REQ_I  = 1'b0;
        bus.ADDR_I = 14'h3333;
        wait_idle();

        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (expq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("queue_drain", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
